// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares one 4-to-1 mux datapath among four requesters.
// Grants are held until done, request drop, or the HOLD_MAX timeout.
module mux_rr_arbiter #(
    parameter int CNT_WIDTH = 4,
    parameter int HOLD_MAX  = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    input  logic       done_i,
    output logic [3:0] grant_o,
    output logic [1:0] select_o,
    output logic       valid_o,
    output logic       timeout_o
);

    typedef enum logic {
        IDLE,
        GRANT
    } arbState_e;

    localparam bit                   TIMEOUT_EN = (HOLD_MAX != 0);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST  = CNT_WIDTH'(HOLD_MAX - 1);

    arbState_e            state_q, state_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [1:0]           own_q, own_d;
    logic [CNT_WIDTH-1:0] holdCnt_q, holdCnt_d;
    logic [3:0]           grant_q, grant_d;
    logic [1:0]           select_q, select_d;
    logic                 valid_q, valid_d;
    logic                 timeout_q, timeout_d;

    logic                 relDone, relDrop, relTimeout, release_w;
    logic [2:0]           search;

    // Returns {found, index} of the first set request scanning upward from start.
    function automatic logic [2:0] findWinner(input logic [3:0] req, input logic [1:0] start);
        logic       found;
        logic [1:0] idx;
        logic [1:0] win;
        found = 1'b0;
        win   = start;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        own_d      = own_q;
        holdCnt_d  = holdCnt_q;
        grant_d    = grant_q;
        select_d   = select_q;
        valid_d    = valid_q;
        timeout_d  = 1'b0;
        relDone    = done_i;
        relDrop    = !req_i[own_q];
        relTimeout = TIMEOUT_EN && (holdCnt_q == HOLD_LAST);
        release_w  = relDone || relDrop || relTimeout;
        search     = findWinner(req_i, (state_q == IDLE) ? ptr_q : own_q + 2'd1);

        unique case (state_q)
            IDLE: begin
                if (search[2]) begin
                    state_d   = GRANT;
                    own_d     = search[1:0];
                    grant_d   = 4'b0001 << search[1:0];
                    select_d  = search[1:0];
                    valid_d   = 1'b1;
                    holdCnt_d = '0;
                end else begin
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (release_w) begin
                    // The releasing owner is searched last, so it only wins when alone.
                    ptr_d     = own_q + 2'd1;
                    timeout_d = relTimeout && !relDone && !relDrop;
                    holdCnt_d = '0;
                    if (search[2]) begin
                        own_d    = search[1:0];
                        grant_d  = 4'b0001 << search[1:0];
                        select_d = search[1:0];
                        valid_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                        valid_d = 1'b0;
                    end
                end else begin
                    holdCnt_d = holdCnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            own_q     <= 2'd0;
            holdCnt_q <= '0;
            grant_q   <= 4'b0000;
            select_q  <= 2'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            own_q     <= own_d;
            holdCnt_q <= holdCnt_d;
            grant_q   <= grant_d;
            select_q  <= select_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o   = grant_q;
    assign select_o  = select_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer that shares one `MUX_4to1` datapath among four requesters. It drives the mux `select` from registered state and holds each grant until the owner signals completion, drops its request, or exceeds a hold limit. Requesters sit in the CPU datapath (for example, write-back sources contending for one result bus), and its `select_o` connects directly to the 4-to-1 mux `select` input.

## Interface
- `CNT_WIDTH`, default 4: width of the hold counter.
- `HOLD_MAX`, default 15: maximum cycles a grant may be held before forced release. 0 disables the timeout. Must be < 2^CNT_WIDTH.
- `clk_i` input 1: clock. All state updates on the rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `req_i` input 4: request, one bit per requester (bit n = mux input `data<n>`).
- `done_i` input 1: current owner finishes its transfer this cycle. Ignored when no grant is active.
- `grant_o` output 4: registered one-hot grant, or all zeros.
- `select_o` output 2: registered index of the granted requester, driving mux `select`.
- `valid_o` output 1: high while a grant is active (`grant_o != 0`).
- `timeout_o` output 1: one-cycle pulse in the cycle a grant is force-released by `HOLD_MAX`.

## Operation
- State: FSM {IDLE, GRANT}, 2-bit priority pointer `ptr`, 2-bit owner index `own`, and `hold_cnt[CNT_WIDTH-1:0]`.
- Reset values:
  - state = IDLE, `ptr` = 0, `own` = 0, `hold_cnt` = 0.
  - `grant_o` = 0000, `select_o` = 00, `valid_o` = 0, `timeout_o` = 0.
- Winner search:
  - Scan `req_i` starting at index `ptr`, then `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
  - The first set bit wins.
- IDLE:
  - If `req_i != 0`: winner w; next state GRANT; `own` <= w; `grant_o` <= 1<<w; `select_o` <= w; `valid_o` <= 1; `hold_cnt` <= 0.
  - Otherwise stay in IDLE with outputs 0. `select_o` holds its last value, which is don't-care while `valid_o` = 0.
- GRANT: release occurs when any of these holds:
  - (a) `done_i` = 1;
  - (b) `req_i[own]` = 0;
  - (c) `HOLD_MAX` != 0 and `hold_cnt` == `HOLD_MAX`-1.
- GRANT, no release: `hold_cnt` <= `hold_cnt`+1; outputs unchanged.
- GRANT, on release:
  - `ptr` <= `own`+1 (mod 4).
  - Rerun the winner search immediately, starting at `own`+1, using current `req_i`. The releasing owner therefore has lowest priority.
  - If a winner exists, re-grant back-to-back with no idle cycle: update `own`/`grant_o`/`select_o`, keep `valid_o` = 1, `hold_cnt` <= 0.
  - If no winner, go to IDLE with `grant_o` <= 0 and `valid_o` <= 0.
  - The same requester may be re-granted only if it is the sole requester after release.
- `timeout_o` <= 1 for exactly one cycle when release cause (c) applies and neither (a) nor (b) does. Otherwise 0.
- Simultaneous causes: (a) and (b) take precedence over (c) for `timeout_o`. Behaviour is otherwise identical.
- Reset mid-grant: outputs return to reset values the cycle after `rst_i` is sampled high. Any in-flight transfer is abandoned.
- `done_i` and `req_i` are sampled only at clock edges. No combinational path from inputs to outputs.

## Timing
- Grant latency: `req_i` seen in IDLE at edge N, `grant_o`/`select_o`/`valid_o` valid after edge N (visible in cycle N+1).
- Handover latency: release sampled at edge N, new owner's `grant_o`/`select_o` valid from cycle N+1. No bubble cycle.
- Grant duration: minimum 1 cycle (`done_i` in the first GRANT cycle). Maximum `HOLD_MAX` cycles when the timeout is enabled.
- Mux output `data_o` reflects the new owner in the same cycle `select_o` changes, since the mux is combinational.
- Fairness: with all four requesting continuously and `done_i` pulsed every cycle, the grant order is 0,1,2,3,0,… with one grant per cycle.

## Test plan
- Reset then single request:
  - `rst_i`=1 for 2 cycles, then `req_i`=0100.
  - Next cycle: `grant_o`=0100, `select_o`=10, `valid_o`=1.
  - `done_i`=1 with `req_i`=0000: `grant_o`=0000, `valid_o`=0.
- Round-robin rotation:
  - `req_i`=1111 held, `done_i`=1 every cycle.
  - `select_o` sequence is 00,01,10,11,00 on consecutive cycles; `valid_o` stays 1.
- Timeout:
  - `HOLD_MAX`=4, `req_i`=0011 held, `done_i`=0.
  - Owner 0 holds for 4 cycles; `timeout_o` pulses once; owner 1 granted the next cycle; no idle cycle.
- Request drop and sole requester:
  - Owner 2 drops `req_i[2]` with `req_i`=0000: go to IDLE.
  - Owner 3 with `req_i`=1000 and `done_i`=1: owner 3 is re-granted back-to-back and `ptr`=0.
- Reset mid-grant:
  - `rst_i`=1 while owner 1 holds, `req_i`=1111.
  - Next cycle: all outputs 0.
  - After `rst_i`=0: owner 0 granted (`ptr` reset to 0).
- Simultaneous timeout and done:
  - `HOLD_MAX`=3, `done_i`=1 in the third GRANT cycle.
  - Release occurs and `timeout_o` stays 0.
